// File: rtl/pipe_control_unit.sv
// Purpose : decodes the ID-stage opcode into the 8-bit control byte and carries it through EX/MEM/WB with dest-register tags.
// Latency : combinational decode in ID; instruction in ID at cycle n reaches EX at n+1, MEM at n+2 and WB at n+3.
// Backpres: none; stages advance every cycle. A load-use hazard raises stall_o and injects one bubble into EX.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   valid_i, op_i, rs_i, rt_i, rd_i
//                                 instruction currently in ID
//   flush_i                       kill the ID instruction (taken branch / resolved jump)
//   id_ctrl_o, branch_o, jump_o, illegal_o
//                                 combinational decode of op_i
//   stall_o                       hold PC and IF/ID this cycle
//   ex/mem/wb_ctrl_o, ex/mem/wb_wreg_o
//                                 control word and destination register per stage
module pipe_control_unit #(
    parameter int CTRL_W = 32,
    parameter int REG_AW = 5,
    parameter bit HAZ_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [5:0]        op_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] id_ctrl_o,
    output logic              branch_o,
    output logic              jump_o,
    output logic              illegal_o,
    output logic              stall_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [REG_AW-1:0] ex_wreg_o,
    output logic [CTRL_W-1:0] mem_ctrl_o,
    output logic [REG_AW-1:0] mem_wreg_o,
    output logic [CTRL_W-1:0] wb_ctrl_o,
    output logic [REG_AW-1:0] wb_wreg_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Control byte bit positions: {RegDst,ALUSrc,ALUOp[1:0],MemWrite,MemRead,MemtoReg,RegWrite}
    localparam int B_REGDST  = 7;
    localparam int B_MEMREAD = 2;
    localparam int B_REGWR   = 0;

    logic [7:0]        dec_ctrl;
    logic              dec_known;
    logic              uses_rt;
    logic [REG_AW-1:0] dest_reg;
    logic              dest_wr;
    logic [7:0]        id_ctrl_gated;
    logic [REG_AW-1:0] id_wreg_gated;
    logic              hazard;
    logic              bubble;

    logic [7:0]        ex_ctrl_q,  mem_ctrl_q,  wb_ctrl_q;
    logic [REG_AW-1:0] ex_wreg_q,  mem_wreg_q,  wb_wreg_q;

    always_comb begin
        dec_ctrl  = 8'h00;
        dec_known = 1'b1;
        unique case (op_i)
            OP_R:    dec_ctrl = 8'h81;
            OP_ADDI: dec_ctrl = 8'h51;
            OP_LW:   dec_ctrl = 8'h57;
            OP_SW:   dec_ctrl = 8'h58;
            OP_ORI:  dec_ctrl = 8'h61;
            OP_BEQ:  dec_ctrl = 8'h30;
            OP_J:    dec_ctrl = 8'h00;
            default: dec_known = 1'b0;
        endcase
    end

    assign id_ctrl_o = CTRL_W'(dec_ctrl);
    assign branch_o  = (op_i == OP_BEQ);
    assign jump_o    = (op_i == OP_J);
    assign illegal_o = valid_i & ~dec_known;

    // Only these formats read rt as a source; for I-type ALU ops and lw, rt is the destination.
    assign uses_rt = (op_i == OP_R) | (op_i == OP_SW) | (op_i == OP_BEQ);

    // A write to r0 is architecturally a no-op, so strip RegWrite and zero the tag
    // so that no later hazard compare can match on r0.
    assign dest_reg = dec_ctrl[B_REGDST] ? rd_i : rt_i;
    assign dest_wr  = dec_ctrl[B_REGWR] & (dest_reg != '0);

    always_comb begin
        id_ctrl_gated         = dec_ctrl;
        id_ctrl_gated[B_REGWR] = dest_wr;
        id_wreg_gated         = dest_wr ? dest_reg : '0;
    end

    // The load in EX has its data only after MEM; a dependent instruction in ID must
    // wait one cycle. The injected bubble clears EX MemRead, so the stall self-releases.
    assign hazard = ex_ctrl_q[B_MEMREAD] & (ex_wreg_q != '0) &
                    ((ex_wreg_q == rs_i) | ((ex_wreg_q == rt_i) & uses_rt));

    assign stall_o = HAZ_EN & valid_i & ~flush_i & hazard;
    assign bubble  = ~valid_i | flush_i | stall_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctrl_q  <= '0;
            ex_wreg_q  <= '0;
            mem_ctrl_q <= '0;
            mem_wreg_q <= '0;
            wb_ctrl_q  <= '0;
            wb_wreg_q  <= '0;
        end else begin
            if (bubble) begin
                ex_ctrl_q <= '0;
                ex_wreg_q <= '0;
            end else begin
                ex_ctrl_q <= id_ctrl_gated;
                ex_wreg_q <= id_wreg_gated;
            end
            mem_ctrl_q <= ex_ctrl_q;
            mem_wreg_q <= ex_wreg_q;
            wb_ctrl_q  <= mem_ctrl_q;
            wb_wreg_q  <= mem_wreg_q;
        end
    end

    assign ex_ctrl_o  = CTRL_W'(ex_ctrl_q);
    assign ex_wreg_o  = ex_wreg_q;
    assign mem_ctrl_o = CTRL_W'(mem_ctrl_q);
    assign mem_wreg_o = mem_wreg_q;
    assign wb_ctrl_o  = CTRL_W'(wb_ctrl_q);
    assign wb_wreg_o  = wb_wreg_q;

endmodule
